regfile_dump: RTL

//  Sequential reader for the register file: on start, walks every location through one

---
 rtl/regfile_dump_pkg.sv | 11 +
 rtl/regfile_dump.sv | 101 ++++++++++
 2 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump engine.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks every location through one combinational read port
// and streams (address, data) pairs out over a valid/ready handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int Nloc      = 32,
  parameter int Dbits     = 32,
  parameter int SKIP_ZERO = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(Nloc)-1:0] rd_addr,
  input  logic [Dbits-1:0]        rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(Nloc)-1:0] out_addr,
  output logic [Dbits-1:0]        out_data
);

  localparam int AW = $clog2(Nloc);
  localparam logic [AW-1:0] FIRST = AW'((SKIP_ZERO != 0) ? 1 : 0);
  localparam logic [AW-1:0] LAST  = AW'(Nloc - 1);

  dump_state_t      state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             valid_d;
  logic [AW-1:0]    addr_d;
  logic [Dbits-1:0] data_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_valid <= valid_d;
      out_addr  <= addr_d;
      out_data  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = out_valid;
    addr_d  = out_addr;
    data_d  = out_data;
    // Abort pre-empts every active state; in IDLE it also masks a coincident start.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            idx_d   = FIRST;
            state_d = LOAD;
          end
        end
        LOAD: begin
          data_d  = rd_data;
          addr_d  = idx_q;
          valid_d = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (idx_q == LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status is decoded from the registered state so reset drops it without a clock edge.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_addr = idx_q;

endmodule
